spi_slave_adis: RTL

SPI mode-3 (CPOL=1, CPHA=1) slave that answers the ADIS16209-style SPI master on the marine-radar FPGA: it receives 16-bit frames on MOSI and returns a host-supplied word on MISO. It serves as a bench/loopback sensor emulator and as a board-to-board SPI responder. SCLCK/CS/MOSI are asynchronous to `clock`; the block oversamples them through 2-flop synchronizers and works fully in the `clock` domain.

---
 rtl/spi_slave_adis.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_adis.sv
// SPI mode-3 slave: receives word_size-bit frames on MOSI and returns a host-loaded word on MISO.
// SCLCK/CS/MOSI are oversampled through 2-flop synchronizers; everything else runs on clock.
module spi_slave_adis #(
   parameter int unsigned word_size = 16,
   parameter logic        miso_rest = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 SCLCK,
   input  logic                 CS,
   input  logic                 MOSI,
   output logic                 MISO,
   input  logic                 strobe_out,
   input  logic [word_size-1:0] value_out,
   output logic                 strobe_in,
   output logic [word_size-1:0] value_in,
   output logic                 tx_underrun,
   output logic                 frame_error,
   output logic [7:0]           debug
);

   localparam logic [7:0] WS = 8'(word_size);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      SHIFT = 3'd2,
      DONE  = 3'd3,
      FLUSH = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           sck_sync_q, sck_sync_d;
   logic [2:0]           cs_sync_q, cs_sync_d;
   logic [1:0]           mosi_sync_q, mosi_sync_d;
   logic [word_size-1:0] tx_hold_q, tx_hold_d;
   logic [word_size-1:0] tx_shift_q, tx_shift_d;
   logic [word_size-1:0] rx_shift_q, rx_shift_d;
   logic [word_size-1:0] value_in_q, value_in_d;
   logic [7:0]           bit_count_q, bit_count_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 miso_q, miso_d;
   logic                 strobe_pend_q, strobe_pend_d;
   logic                 strobe_in_q, strobe_in_d;
   logic                 tx_underrun_q, tx_underrun_d;
   logic                 frame_error_q, frame_error_d;
   logic                 sck_fall, sck_rise, cs_fall, cs_rise, mosi_s;

   // [0],[1] form the synchronizer; [2] is the edge-detect history flop
   assign sck_sync_d  = {sck_sync_q[1:0], SCLCK};
   assign cs_sync_d   = {cs_sync_q[1:0], CS};
   assign mosi_sync_d = {mosi_sync_q[0], MOSI};

   assign sck_fall = sck_sync_q[2] & ~sck_sync_q[1];
   assign sck_rise = ~sck_sync_q[2] & sck_sync_q[1];
   assign cs_fall  = cs_sync_q[2] & ~cs_sync_q[1];
   assign cs_rise  = ~cs_sync_q[2] & cs_sync_q[1];
   assign mosi_s   = mosi_sync_q[1];

   always_comb begin
      state_d       = state_q;
      tx_hold_d     = tx_hold_q;
      tx_valid_d    = tx_valid_q;
      tx_shift_d    = tx_shift_q;
      rx_shift_d    = rx_shift_q;
      value_in_d    = value_in_q;
      bit_count_d   = bit_count_q;
      miso_d        = miso_q;
      strobe_pend_d = 1'b0;
      strobe_in_d   = strobe_pend_q;
      tx_underrun_d = 1'b0;
      frame_error_d = 1'b0;

      if (strobe_out) begin
         tx_hold_d  = value_out;
         tx_valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            miso_d = miso_rest;
            if (cs_fall) begin
               // a word strobed in this very cycle counts as fresh
               tx_shift_d    = strobe_out ? value_out : tx_hold_q;
               tx_underrun_d = ~strobe_out & ~tx_valid_q;
               tx_valid_d    = 1'b0;
               bit_count_d   = 8'd0;
               state_d       = ARMED;
            end
         end
         ARMED, SHIFT: begin
            if (sck_fall) begin
               miso_d     = tx_shift_q[word_size-1];
               tx_shift_d = tx_shift_q << 1;
               state_d    = SHIFT;
            end else if (sck_rise && state_q == SHIFT) begin
               rx_shift_d  = {rx_shift_q[word_size-2:0], mosi_s};
               bit_count_d = bit_count_q + 8'd1;
               if (bit_count_q == WS - 8'd1) begin
                  value_in_d    = {rx_shift_q[word_size-2:0], mosi_s};
                  strobe_pend_d = 1'b1;
                  state_d       = DONE;
               end
            end
         end
         DONE: begin
            if (sck_fall) miso_d = miso_rest;
            else if (sck_rise) state_d = FLUSH;
         end
         FLUSH: begin
            if (sck_fall) miso_d = miso_rest;
         end
         default: state_d = IDLE;
      endcase

      // CS release is evaluated after any same-cycle SCLCK rise
      if (cs_rise && state_q != IDLE) begin
         frame_error_d = (bit_count_d != WS) || (state_d == FLUSH);
         miso_d        = miso_rest;
         state_d       = IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sck_sync_q    <= 3'b111;
         cs_sync_q     <= 3'b111;
         mosi_sync_q   <= 2'b00;
         state_q       <= IDLE;
         tx_hold_q     <= '0;
         tx_valid_q    <= 1'b0;
         tx_shift_q    <= '0;
         rx_shift_q    <= '0;
         value_in_q    <= '0;
         bit_count_q   <= 8'd0;
         miso_q        <= miso_rest;
         strobe_pend_q <= 1'b0;
         strobe_in_q   <= 1'b0;
         tx_underrun_q <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         sck_sync_q    <= sck_sync_d;
         cs_sync_q     <= cs_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         state_q       <= state_d;
         tx_hold_q     <= tx_hold_d;
         tx_valid_q    <= tx_valid_d;
         tx_shift_q    <= tx_shift_d;
         rx_shift_q    <= rx_shift_d;
         value_in_q    <= value_in_d;
         bit_count_q   <= bit_count_d;
         miso_q        <= miso_d;
         strobe_pend_q <= strobe_pend_d;
         strobe_in_q   <= strobe_in_d;
         tx_underrun_q <= tx_underrun_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign MISO        = miso_q;
   assign strobe_in   = strobe_in_q;
   assign value_in    = value_in_q;
   assign tx_underrun = tx_underrun_q;
   assign frame_error = frame_error_q;
   assign debug       = {tx_valid_q, bit_count_q[3:0], state_q};

endmodule
